counter_step_ctrl: RTL and testbench

Upstream control stage for the 8-bit up/down counter. Converts two raw push-button inputs into the counter's `enable` and `direction` controls. Synchronises and debounces each button, then runs a small state machine that issues a one-cycle `enable` pulse per press, with optional auto-repeat while a button is held. Its outputs connect directly to the counter's `enable` and `direction` inputs on the same clock.

---
 rtl/counter_step_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_counter_step_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl: turns the raw up/down push-buttons into the counter's
// enable/direction controls. Each button is synchronised and debounced. A
// small FSM then emits one enable pulse per accepted press.
// Optional auto-repeat while a button is held: define COUNTER_STEP_AUTOREPEAT_EN.
module counter_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic direction
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned REP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        LOCK = 2'd3
    } state_t;

    // Elaboration-time sanity checks on the timing parameters
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("counter_step_ctrl: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 255) begin : g_bad_delay
        $error("counter_step_ctrl: REPEAT_DELAY must be in 2..255");
    end
    if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_period
        $error("counter_step_ctrl: REPEAT_PERIOD must be in 2..REPEAT_DELAY");
    end

    logic            meta_up;
    logic            meta_down;
    logic            s_up;
    logic            s_down;
    logic [DB_W-1:0] db_cnt_up;
    logic [DB_W-1:0] db_cnt_down;
    logic            d_up;
    logic            d_down;

    state_t          state;
    state_t          state_next;
    logic            enable_next;
    logic            direction_next;

`ifdef COUNTER_STEP_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic [REP_W-1:0] rep_inc;
`endif

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_up   <= 1'b0;
            s_up      <= 1'b0;
            meta_down <= 1'b0;
            s_down    <= 1'b0;
        end else begin
            meta_up   <= btn_up;
            s_up      <= meta_up;
            meta_down <= btn_down;
            s_down    <= meta_down;
        end
    end

    // Up debounce: flip on the DEBOUNCE_CYCLES-th consecutive differing sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_up <= '0;
            d_up      <= 1'b0;
        end else if (s_up == d_up) begin
            db_cnt_up <= '0;
        end else if (db_cnt_up == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_up <= '0;
            d_up      <= s_up;
        end else begin
            db_cnt_up <= db_cnt_up + DB_W'(1);
        end
    end

    // Down debounce: same scheme as the up button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_down <= '0;
            d_down      <= 1'b0;
        end else if (s_down == d_down) begin
            db_cnt_down <= '0;
        end else if (db_cnt_down == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_down <= '0;
            d_down      <= s_down;
        end else begin
            db_cnt_down <= db_cnt_down + DB_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            enable    <= 1'b0;
            direction <= 1'b1;
        end else begin
            state     <= state_next;
            enable    <= enable_next;
            direction <= direction_next;
        end
    end

`ifdef COUNTER_STEP_AUTOREPEAT_EN
    // Repeat counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_next;
        end
    end

    // Saturating increment of the repeat counter
    always_comb begin
        rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + REP_W'(1);
    end
`endif

    // Next-state, step pulse and direction decode
    always_comb begin
        state_next     = state;
        enable_next    = 1'b0;
        direction_next = direction;
`ifdef COUNTER_STEP_AUTOREPEAT_EN
        rep_next       = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (d_up && !d_down) begin
                    state_next     = UP;
                    direction_next = 1'b1;
                    enable_next    = 1'b1;
                end else if (d_down && !d_up) begin
                    state_next     = DOWN;
                    direction_next = 1'b0;
                    enable_next    = 1'b1;
                end else if (d_up && d_down) begin
                    state_next = LOCK;
                end
            end
            UP: begin
                if (!d_up) begin
                    state_next = IDLE;
                end else if (d_down) begin
                    state_next = LOCK;
                end
            end
            DOWN: begin
                if (!d_down) begin
                    state_next = IDLE;
                end else if (d_up) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (!d_up && !d_down) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef COUNTER_STEP_AUTOREPEAT_EN
        // Repeats only fire while staying in UP/DOWN; entry restarts the count
        if ((state_next == UP || state_next == DOWN) && state_next != state) begin
            rep_next = '0;
        end else if ((state == UP || state == DOWN) && state_next == state) begin
            if (rep_inc == REP_W'(REPEAT_DELAY)) begin
                enable_next = 1'b1;
                rep_next    = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rep_next = rep_inc;
            end
        end
`endif
    end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Testbench for counter_step_ctrl: directed button sequences, expected enable
// pulses (cycle and direction) queued by the stimulus and checked by a monitor.
module tb_counter_step_ctrl;

    localparam int PRESS_LAT = 7;   // edges from first button sample to enable pulse

    typedef struct {
        int   at;
        logic dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic enable;
    logic direction;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    counter_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .enable   (enable),
        .direction(direction)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_pulse(input int at, input logic dir);
        exp_q.push_back('{at: at, dir: dir});
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold the given buttons for 'hold' samples, release, then idle for 'gap' cycles
    task automatic press(input logic up, input logic dn, input int hold, input int gap);
        btn_up   = up;
        btn_down = dn;
        repeat (hold) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: every enable pulse must match the head of the expectation queue
    always @(negedge clk) begin : monitor
        exp_t item;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                item = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse: no enable at cycle %0d (dir %b), now cycle %0d",
                         item.at, item.dir, cyc);
            end
            if (enable === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: enable=1 at cycle %0d, expected none", cyc);
                end else begin
                    item = exp_q.pop_front();
                    if (item.at != cyc) begin
                        errors++;
                        $display("FAIL pulse_cycle: pulse at cycle %0d, expected cycle %0d",
                                 cyc, item.at);
                    end
                    checks++;
                    if (direction !== item.dir) begin
                        errors++;
                        $display("FAIL pulse_dir: direction=%b at cycle %0d, expected %b",
                                 direction, cyc, item.dir);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int r;

        // Reset asserted mid-period takes effect immediately
        #12;
        rst = 1'b1;
        #1;
        check_bit("reset_enable", enable, 1'b0);
        check_bit("reset_direction", direction, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_bit("idle_enable", enable, 1'b0);
        check_bit("idle_direction", direction, 1'b1);

        // Long up press: one pulse (plus repeats when compiled in)
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b1);
`ifdef COUNTER_STEP_AUTOREPEAT_EN
        expect_pulse(c + PRESS_LAT + 16, 1'b1);
        expect_pulse(c + PRESS_LAT + 20, 1'b1);
        expect_pulse(c + PRESS_LAT + 24, 1'b1);
        expect_pulse(c + PRESS_LAT + 28, 1'b1);
`endif
        press(1'b1, 1'b0, 30, 14);

        // Short down glitch: ignored, direction unchanged
        press(1'b0, 1'b1, 3, 12);
        check_bit("glitch_down_direction", direction, 1'b1);

        // Real down press
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b0);
        press(1'b0, 1'b1, 10, 12);
        check_bit("down_held_direction", direction, 1'b0);

        // Both together: LOCK, no pulse, direction untouched
        press(1'b1, 1'b1, 20, 12);
        check_bit("lock_direction", direction, 1'b0);

        // Up after lock release
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b1);
        press(1'b1, 1'b0, 10, 12);

        // Debounce boundary: 3 samples rejected, 4 samples accepted
        press(1'b1, 1'b0, 3, 12);
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b1);
        press(1'b1, 1'b0, 4, 12);

        // UP -> LOCK while up held; release down then up: no further pulses
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b1);
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_down = 1'b1;
        repeat (15) @(negedge clk);
        btn_down = 1'b0;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        check_bit("after_lock_direction", direction, 1'b1);

        // Reset while down is held, then treated as a fresh press
        c = cyc;
        expect_pulse(c + PRESS_LAT, 1'b0);
        btn_down = 1'b1;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bit("midrst_enable", enable, 1'b0);
        check_bit("midrst_direction", direction, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("midrst_hold_enable", enable, 1'b0);
        check_bit("midrst_hold_direction", direction, 1'b1);
        rst = 1'b0;
        r = cyc;
        expect_pulse(r + PRESS_LAT, 1'b0);
        repeat (2) @(negedge clk);
        check_bit("postrst_direction", direction, 1'b1);
        repeat (8) @(negedge clk);
        btn_down = 1'b0;
        repeat (20) @(negedge clk);
        check_bit("final_enable", enable, 1'b0);
        check_bit("final_direction", direction, 1'b0);

        // Any expectation still queued was never seen
        while (exp_q.size() > 0) begin
            exp_t item;
            item = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse_end: no enable at cycle %0d (dir %b)", item.at, item.dir);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
